adsr_envelope: RTL and testbench

//  Downstream amplitude stage for the wavetable oscillator. Takes the 16-bit

---
 rtl/adsr_envelope_if.sv | 43 ++++
 rtl/adsr_envelope.sv | 111 +++++++++++
 tb/tb_adsr_envelope.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/adsr_envelope_if.sv
// Sample/control bundle between the oscillator/control side and the ADSR amplitude stage.
// The envelope stage drives out/env/active; the control side drives everything else.
interface adsr_envelope_if #(
    parameter int DATA_W = 16,
    parameter int ENV_W  = 16
);
    logic                     sample_Clk;
    logic                     gate;
    logic [ENV_W-1:0]         attack_rate;
    logic [ENV_W-1:0]         decay_rate;
    logic [ENV_W-1:0]         sustain_level;
    logic [ENV_W-1:0]         release_rate;
    logic signed [DATA_W-1:0] in;
    logic signed [DATA_W-1:0] out;
    logic [ENV_W-1:0]         env;
    logic                     active;

    modport master (
        output sample_Clk,
        output gate,
        output attack_rate,
        output decay_rate,
        output sustain_level,
        output release_rate,
        output in,
        input  out,
        input  env,
        input  active
    );

    modport slave (
        input  sample_Clk,
        input  gate,
        input  attack_rate,
        input  decay_rate,
        input  sustain_level,
        input  release_rate,
        input  in,
        output out,
        output env,
        output active
    );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR amplitude stage: 5-state envelope stepped on each sample strobe, output = sample * level.
// Output uses the pre-update level, so out lags env by one strobe.
module adsr_envelope #(
    parameter int DATA_W = 16,
    parameter int ENV_W  = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    adsr_envelope_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } state_t;

    localparam logic [ENV_W:0] FULL_SCALE = {1'b0, {ENV_W{1'b1}}};

    state_t                   state_q;
    state_t                   state_n;
    state_t                   phase;
    logic [ENV_W-1:0]         env_q;
    logic [ENV_W-1:0]         env_n;
    logic signed [DATA_W-1:0] out_q;
    logic signed [DATA_W-1:0] out_n;
    logic                     gate_q;
    logic                     rise;
    logic [ENV_W:0]           att_sum;
    logic signed [ENV_W:0]    dec_diff;
    logic signed [ENV_W:0]    rel_diff;
    logic signed [DATA_W+ENV_W-1:0] prod;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            env_q   <= '0;
            out_q   <= '0;
            gate_q  <= 1'b0;
        end else if (bus.sample_Clk) begin
            state_q <= state_n;
            env_q   <= env_n;
            out_q   <= out_n;
            gate_q  <= bus.gate;
        end
    end

    // The gate events pick the phase whose step is applied on this same strobe,
    // so a retrigger or note-off already moves the level on the strobe that sees it.
    always_comb begin
        rise     = bus.gate & ~gate_q;
        att_sum  = {1'b0, env_q} + {1'b0, bus.attack_rate};
        dec_diff = $signed({1'b0, env_q}) - $signed({1'b0, bus.decay_rate});
        rel_diff = $signed({1'b0, env_q}) - $signed({1'b0, bus.release_rate});
        prod     = $signed(bus.in) * $signed({1'b0, env_q});
        out_n    = DATA_W'(prod >>> ENV_W);

        phase = state_q;
        if (rise) begin
            phase = ATTACK;
        end else if (!bus.gate && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
            phase = RELEASE;
        end

        state_n = phase;
        env_n   = env_q;
        case (phase)
            IDLE: begin
                env_n = '0;
            end
            ATTACK: begin
                if (att_sum >= FULL_SCALE) begin
                    env_n   = '1;
                    state_n = DECAY;
                end else begin
                    env_n = att_sum[ENV_W-1:0];
                end
            end
            DECAY: begin
                if (dec_diff <= $signed({1'b0, bus.sustain_level})) begin
                    env_n   = bus.sustain_level;
                    state_n = SUSTAIN;
                end else begin
                    env_n = dec_diff[ENV_W-1:0];
                end
            end
            SUSTAIN: begin
                env_n = bus.sustain_level;
            end
            RELEASE: begin
                if (rel_diff[ENV_W] || (rel_diff == '0)) begin
                    env_n   = '0;
                    state_n = IDLE;
                end else begin
                    env_n = rel_diff[ENV_W-1:0];
                end
            end
            default: begin
                env_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.out    = out_q;
    assign bus.env    = env_q;
    assign bus.active = (state_q != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: behavioural envelope model feeds a scoreboard, one entry per Clk,
// plus fixed-value checks at the notable points of each note phase.
module tb_adsr_envelope;

    localparam int DATA_W = 16;
    localparam int ENV_W  = 16;

    localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    adsr_envelope_if #(.DATA_W(DATA_W), .ENV_W(ENV_W)) bus ();

    adsr_envelope #(.DATA_W(DATA_W), .ENV_W(ENV_W)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] env;
        logic [15:0] out;
        logic        active;
    } exp_t;

    exp_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    string phase_tag = "init";

    int m_state = S_IDLE;
    int m_env   = 0;
    int m_out   = 0;
    bit m_gq    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference envelope, written from the behavioural description with plain integers.
    task automatic model_step();
        int     st;
        int     e;
        int     sin;
        longint p;
        bit     g;
        g   = bus.gate;
        sin = int'($signed(bus.in));
        p   = longint'(sin) * longint'(m_env);
        m_out = int'(p >>> 16) & 32'h0000FFFF;
        st = m_state;
        e  = m_env;
        if (g && !m_gq) st = S_ATT;
        else if (!g && (st == S_ATT || st == S_DEC || st == S_SUS)) st = S_REL;
        case (st)
            S_ATT: begin
                e = e + int'(bus.attack_rate);
                if (e >= 65535) begin e = 65535; st = S_DEC; end
            end
            S_DEC: begin
                e = e - int'(bus.decay_rate);
                if (e <= int'(bus.sustain_level)) begin e = int'(bus.sustain_level); st = S_SUS; end
            end
            S_SUS: e = int'(bus.sustain_level);
            S_REL: begin
                e = e - int'(bus.release_rate);
                if (e <= 0) begin e = 0; st = S_IDLE; end
            end
            default: e = 0;
        endcase
        m_state = st;
        m_env   = e;
        m_gq    = g;
    endtask

    task automatic cycle(input bit stb);
        exp_t e;
        @(negedge Clk);
        bus.sample_Clk = stb;
        if (!Reset) begin
            m_state = S_IDLE; m_env = 0; m_out = 0; m_gq = 1'b0;
        end else if (stb) begin
            model_step();
        end
        e.env    = m_env[15:0];
        e.out    = m_out[15:0];
        e.active = (m_state != S_IDLE);
        sb.push_back(e);
        @(posedge Clk);
        #1;
        bus.sample_Clk = 1'b0;
        e = sb.pop_front();
        check({phase_tag, "_env"},    {16'h0000, bus.env}, {16'h0000, e.env});
        check({phase_tag, "_out"},    {16'h0000, bus.out}, {16'h0000, e.out});
        check({phase_tag, "_active"}, {31'h0, bus.active}, {31'h0, e.active});
    endtask

    // One strobe followed by one idle Clk, which checks that registers hold between strobes.
    task automatic step();
        cycle(1'b1);
        cycle(1'b0);
    endtask

    task automatic expect_now(input string tag, input logic [15:0] env_exp, input logic act_exp);
        check({tag, "_env"},    {16'h0000, bus.env}, {16'h0000, env_exp});
        check({tag, "_active"}, {31'h0, bus.active}, {31'h0, act_exp});
    endtask

    initial begin
        Reset             = 1'b0;
        bus.sample_Clk    = 1'b0;
        bus.gate          = 1'b1;
        bus.attack_rate   = 16'h4000;
        bus.decay_rate    = 16'h0000;
        bus.sustain_level = 16'h8000;
        bus.release_rate  = 16'h0000;
        bus.in            = 16'sh1234;

        phase_tag = "reset";
        repeat (3) cycle(1'b1);
        expect_now("reset_hold", 16'h0000, 1'b0);
        check("reset_out", {16'h0000, bus.out}, 32'h0);

        Reset    = 1'b1;
        bus.gate = 1'b0;
        phase_tag = "idle";
        step();
        expect_now("idle", 16'h0000, 1'b0);

        phase_tag = "attack";
        bus.gate = 1'b1;
        bus.in   = 16'sh4000;
        step(); expect_now("att1", 16'h4000, 1'b1);
        check("att1_out", {16'h0000, bus.out}, 32'h0);
        step(); expect_now("att2", 16'h8000, 1'b1);
        check("att2_out", {16'h0000, bus.out}, 32'h1000);
        step(); expect_now("att3", 16'hC000, 1'b1);
        check("att3_out", {16'h0000, bus.out}, 32'h2000);
        step(); expect_now("att4", 16'hFFFF, 1'b1);
        check("att4_out", {16'h0000, bus.out}, 32'h3000);

        phase_tag = "extreme";
        bus.in = 16'sh7FFF;
        step();
        check("ext_pos_out", {16'h0000, bus.out}, 32'h7FFE);
        bus.in = -16'sh8000;
        step();
        check("ext_neg_out", {16'h0000, bus.out}, 32'h8000);
        expect_now("dec_hold_rate0", 16'hFFFF, 1'b1);

        phase_tag = "decay";
        bus.in         = 16'sh4000;
        bus.decay_rate = 16'h1000;
        step(); expect_now("dec1", 16'hEFFF, 1'b1);
        repeat (9) step();
        expect_now("dec_floor", 16'h8000, 1'b1);
        bus.sustain_level = 16'h6000;
        step(); expect_now("sus_track", 16'h6000, 1'b1);

        phase_tag = "release";
        bus.gate         = 1'b0;
        bus.release_rate = 16'h2000;
        step(); expect_now("rel1", 16'h4000, 1'b1);
        step(); expect_now("rel2", 16'h2000, 1'b1);
        step(); expect_now("rel3", 16'h0000, 1'b0);
        step();
        check("rel_out_zero", {16'h0000, bus.out}, 32'h0);

        phase_tag = "retrig";
        bus.gate        = 1'b1;
        bus.attack_rate = 16'h5000;
        step(); expect_now("rt_att", 16'h5000, 1'b1);
        bus.gate         = 1'b0;
        bus.release_rate = 16'h0000;
        step(); expect_now("rt_rel_hold", 16'h5000, 1'b1);
        bus.gate        = 1'b1;
        bus.attack_rate = 16'h1000;
        step(); expect_now("rt_legato", 16'h6000, 1'b1);
        step(); expect_now("rt_att2", 16'h7000, 1'b1);

        phase_tag = "mid_reset";
        Reset = 1'b0;
        cycle(1'b0);
        expect_now("mid_reset", 16'h0000, 1'b0);
        check("mid_reset_out", {16'h0000, bus.out}, 32'h0);
        Reset = 1'b1;

        phase_tag = "pulse";
        bus.gate         = 1'b1;
        bus.release_rate = 16'h0800;
        step(); expect_now("pulse_att", 16'h1000, 1'b1);
        bus.gate = 1'b0;
        step(); expect_now("pulse_rel", 16'h0800, 1'b1);
        step(); expect_now("pulse_idle", 16'h0000, 1'b0);

        phase_tag = "random";
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) bus.gate = ~bus.gate;
            bus.attack_rate   = 16'($urandom_range(0, 16'h3000));
            bus.decay_rate    = 16'($urandom_range(0, 16'h2000));
            bus.sustain_level = 16'($urandom_range(0, 16'hFFFF));
            bus.release_rate  = 16'($urandom_range(0, 16'h2000));
            bus.in            = 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 79) == 0) Reset = 1'b0;
            cycle(1'b1);
            Reset = 1'b1;
            if ($urandom_range(0, 2) == 0) cycle(1'b0);
        end

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
